// File: rtl/tick_sched_pkg.sv
// Shared encodings and elaboration helpers for the tick scheduler.
package tick_sched_pkg;

  // Configuration command opcodes carried on cfg_op.
  typedef enum logic [1:0] {
    OP_LOAD      = 2'b00,
    OP_START_PER = 2'b01,
    OP_START_ONE = 2'b10,
    OP_STOP      = 2'b11
  } op_e;

  // Per-channel lifecycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ch_state_e;

  // Number of clk cycles per base tick.
  function automatic int unsigned presc_max(input int unsigned clk_freq,
                                            input int unsigned base_freq);
    return clk_freq / base_freq;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One timer channel: stored period, countdown and periodic/one-shot FSM.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick_i,
  input  logic             cmd_en_i,
  input  op_e              cmd_op_i,
  input  logic [CNT_W-1:0] cmd_data_i,
  output logic             start_rej_c,
  output logic             tick_o,
  output logic             running_o,
  output logic             done_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;
  logic             running_q, done_q;

  // Next-state: an accepted command on this channel pre-empts the base tick.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    periodic_d  = periodic_q;
    tick_d      = 1'b0;
    start_rej_c = 1'b0;
    if (cmd_en_i) begin
      case (cmd_op_i)
        OP_LOAD: period_d = cmd_data_i;
        OP_START_PER, OP_START_ONE: begin
          if (period_q == '0) begin
            start_rej_c = 1'b1;
          end else begin
            cnt_d      = period_q - CNT_W'(1);
            periodic_d = (cmd_op_i == OP_START_PER);
            state_d    = ST_RUN;
          end
        end
        OP_STOP: state_d = ST_IDLE;
        default: ;
      endcase
    end else if (base_tick_i && (state_q == ST_RUN)) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        if (periodic_q) begin
          cnt_d = period_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Channel registers; status outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      cnt_q      <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign tick_o    = tick_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared base-tick prescaler, command decode and N_CH timer channels.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int unsigned CLK_FREQ  = 50_000_000,
  parameter  int unsigned BASE_FREQ = 1_000,
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_op,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             cfg_err,
  output logic             base_tick,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  done
);

  localparam int unsigned PRESC_MAX = presc_max(CLK_FREQ, BASE_FREQ);
  localparam int unsigned PRESC_W   = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               base_tick_q, base_tick_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               accept_c;
  logic               ch_ok_c;
  logic [N_CH-1:0]    cmd_en_c;
  logic [N_CH-1:0]    rej_c;
  op_e                op_c;

  // Prescaler wraps at PRESC_MAX-1; base_tick flags the wrap one clk later.
  always_comb begin
    presc_d     = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    base_tick_d = (presc_q == PRESC_LAST);
  end

  // Handshake and routing of an accepted command to its channel.
  always_comb begin
    accept_c = cfg_valid && ready_q;
    ch_ok_c  = (32'(cfg_ch) < N_CH);
    op_c     = op_e'(cfg_op);
    for (int unsigned i = 0; i < N_CH; i++) begin
      cmd_en_c[i] = accept_c && ch_ok_c && (32'(cfg_ch) == i);
    end
    ready_d = !accept_c;
    err_d   = accept_c && (!ch_ok_c || (|rej_c));
  end

  // Top-level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      base_tick_q <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      base_tick_q <= base_tick_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .base_tick_i (base_tick_q),
      .cmd_en_i    (cmd_en_c[g]),
      .cmd_op_i    (op_c),
      .cmd_data_i  (cfg_data),
      .start_rej_c (rej_c[g]),
      .tick_o      (tick[g]),
      .running_o   (running[g]),
      .done_o      (done[g])
    );
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign base_tick = base_tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized scoreboard bench for tick_scheduler with a base-tick-level reference model.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int unsigned CLK_FREQ  = 100;
  localparam int unsigned BASE_FREQ = 10;
  localparam int unsigned N_CH      = 5;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned PM        = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [1:0]       cfg_op = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             cfg_err;
  logic             base_tick;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  running;
  logic [N_CH-1:0]  done;

  always #5 clk = ~clk;

  tick_scheduler #(
    .CLK_FREQ  (CLK_FREQ),
    .BASE_FREQ (BASE_FREQ),
    .N_CH      (N_CH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_op    (cfg_op),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .base_tick (base_tick),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  typedef struct {
    longint          edge_no;
    logic [N_CH-1:0] tk;
    logic            er;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint edge_no  = 0;
  bit     mon_en   = 1'b0;

  // Reference model state, expressed in base ticks remaining until expiry.
  int unsigned     presc_m = 0;
  logic            bt_m    = 1'b0;
  logic            ready_m = 1'b1;
  int unsigned     per_m[N_CH];
  int unsigned     rem_m[N_CH];
  logic [N_CH-1:0] run_v  = '0;
  logic [N_CH-1:0] done_v = '0;
  logic [N_CH-1:0] one_v  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluates each clk edge and queues the pulses it predicts.
  always @(posedge clk or posedge rst) begin
    logic            acc;
    logic            bt_now;
    logic [N_CH-1:0] tk;
    logic            er;
    if (rst) begin
      presc_m = 0;
      bt_m    = 1'b0;
      ready_m = 1'b1;
      run_v   = '0;
      done_v  = '0;
      one_v   = '0;
      for (int i = 0; i < N_CH; i++) begin
        per_m[i] = 0;
        rem_m[i] = 0;
      end
      exp_q.delete();
    end else begin
      edge_no++;
      acc    = cfg_valid && ready_m;
      bt_now = bt_m;
      tk     = '0;
      er     = 1'b0;
      if (acc && (int'(cfg_ch) >= N_CH)) er = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (acc && (int'(cfg_ch) == i)) begin
          case (op_e'(cfg_op))
            OP_LOAD: per_m[i] = cfg_data;
            OP_START_PER, OP_START_ONE: begin
              if (per_m[i] == 0) begin
                er = 1'b1;
              end else begin
                rem_m[i]  = per_m[i];
                run_v[i]  = 1'b1;
                done_v[i] = 1'b0;
                one_v[i]  = (op_e'(cfg_op) == OP_START_ONE);
              end
            end
            default: begin
              run_v[i]  = 1'b0;
              done_v[i] = 1'b0;
            end
          endcase
        end else if (bt_now && run_v[i]) begin
          rem_m[i] = rem_m[i] - 1;
          if (rem_m[i] == 0) begin
            tk[i] = 1'b1;
            if (one_v[i]) begin
              run_v[i]  = 1'b0;
              done_v[i] = 1'b1;
            end else begin
              rem_m[i] = per_m[i];
            end
          end
        end
      end
      ready_m = !acc;
      presc_m = presc_m + 1;
      bt_m    = (presc_m == PM);
      if (bt_m) presc_m = 0;
      if ((tk != '0) || er) exp_q.push_back('{edge_no, tk, er});
    end
  end

  // Monitor: pops the pulse expected for this cycle and compares all outputs.
  always @(negedge clk) begin
    logic [N_CH-1:0] et;
    logic            ee;
    if (mon_en) begin
      et = '0;
      ee = 1'b0;
      while ((exp_q.size() > 0) && (exp_q[0].edge_no < edge_no)) begin
        chk("stale_expect", 64'(exp_q[0].edge_no), 64'(edge_no));
        void'(exp_q.pop_front());
      end
      if ((exp_q.size() > 0) && (exp_q[0].edge_no == edge_no)) begin
        et = exp_q[0].tk;
        ee = exp_q[0].er;
        void'(exp_q.pop_front());
      end
      chk("tick",      64'(tick),      64'(et));
      chk("cfg_err",   64'(cfg_err),   64'(ee));
      chk("base_tick", 64'(base_tick), 64'(bt_m));
      chk("cfg_ready", 64'(cfg_ready), 64'(ready_m));
      chk("running",   64'(running),   64'(run_v));
      chk("done",      64'(done),      64'(done_v));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input op_e op, input logic [CNT_W-1:0] data);
    int n = 0;
    @(negedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_op    = 2'(op);
    cfg_data  = data;
    while ((cfg_ready !== 1'b1) && (n < 8)) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 8) chk("handshake_timeout", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_data  = CNT_W'($urandom);
  endtask

  task automatic send_at_bt(input logic [CH_W-1:0] ch, input op_e op, input logic [CNT_W-1:0] data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((base_tick !== 1'b1) && (n < 40));
    if (base_tick !== 1'b1) chk("base_tick_timeout", 64'(base_tick), 64'd1);
    #1;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_op    = 2'(op);
    cfg_data  = data;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Free-running prescaler with no commands.
    idle(35);

    // Periodic channel 0, period 3.
    send(0, OP_LOAD, 8'd3);
    send(0, OP_START_PER, 8'd0);
    idle(100);

    // One-shot channel 2, period 2, then clear done with STOP.
    send(2, OP_LOAD, 8'd2);
    send(2, OP_START_ONE, 8'd0);
    idle(40);
    send(2, OP_STOP, 8'd0);
    idle(5);

    // Rejections: zero period and out-of-range channels.
    send(1, OP_START_PER, 8'd0);
    send(5, OP_LOAD, 8'd7);
    send(7, OP_START_ONE, 8'd0);
    idle(5);

    // cfg_valid held for four clks; only alternate cycles accept.
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_ch    = 3'd3;
      cfg_op    = 2'(OP_LOAD);
      cfg_data  = CNT_W'(i + 1);
      @(negedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    send(3, OP_START_ONE, 8'd0);
    idle(50);

    // Restart collides with a base tick on the same channel.
    send_at_bt(0, OP_START_PER, 8'd0);
    idle(45);

    // Reset mid-count, then restart from scratch.
    pulse_rst();
    idle(15);
    send(0, OP_LOAD, 8'd3);
    send(0, OP_START_PER, 8'd0);
    idle(40);

    // Randomized command mix.
    repeat (150) begin
      logic [CH_W-1:0]  rch;
      op_e              rop;
      logic [CNT_W-1:0] rdata;
      rch   = CH_W'($urandom_range(0, 7));
      rop   = op_e'($urandom_range(0, 3));
      rdata = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) send_at_bt(rch, rop, rdata);
      else                           send(rch, rop, rdata);
      idle(int'($urandom_range(0, 25)));
      if ($urandom_range(0, 39) == 0) pulse_rst();
    end

    idle(50);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
